// File: rtl/pwm_pattern_sequencer.sv
// Programmable duty pattern engine: ramps duty toward each table entry by one
// LSB per (ramp_div+1) PWM periods, holds it, then advances (one-shot or looping).
module pwm_pattern_sequencer #(
    parameter int unsigned DUTY_W = 6,
    parameter int unsigned STEPS  = 4,
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned DIV_W  = 10,
    localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [DIV_W-1:0]  ramp_div,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              period_tick,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_update,
    output logic              busy,
    output logic [IDX_W-1:0]  step_idx,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic              upd_q, upd_d;
    logic              done_q, done_d;
    logic [DUTY_W-1:0] tbl_duty_q [STEPS];
    logic [DUTY_W-1:0] tbl_duty_d [STEPS];
    logic [HOLD_W-1:0] tbl_hold_q [STEPS];
    logic [HOLD_W-1:0] tbl_hold_d [STEPS];
    logic [IDX_W-1:0]  next_step;

    // Power-of-two table: incrementing the last index wraps naturally to 0.
    assign next_step = step_q + IDX_W'(1);

    always_comb begin
        tbl_duty_d = tbl_duty_q;
        tbl_hold_d = tbl_hold_q;
        if (cfg_we) begin
            tbl_duty_d[cfg_addr] = cfg_duty;
            tbl_hold_d[cfg_addr] = cfg_hold;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        tgt_d      = tgt_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        div_d      = div_q;
        step_d     = step_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;
        // Stop is handled identically in every state: clear duty and return to IDLE.
        if (stop) begin
            state_d = S_IDLE;
            duty_d  = '0;
            upd_d   = (duty_q != '0);
            step_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tgt_d   = tbl_duty_q[0];
                        hold_d  = tbl_hold_q[0];
                        step_d  = '0;
                        div_d   = '0;
                        state_d = S_RAMP;
                    end
                end
                S_RAMP: begin
                    if (duty_q == tgt_q) begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end else if (period_tick) begin
                        if (div_q == ramp_div) begin
                            div_d  = '0;
                            duty_d = (duty_q < tgt_q) ? duty_q + DUTY_W'(1)
                                                      : duty_q - DUTY_W'(1);
                            upd_d  = 1'b1;
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == hold_q) begin
                        if ((step_q == IDX_W'(STEPS - 1)) && !loop_en) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            step_d  = next_step;
                            tgt_d   = tbl_duty_q[next_step];
                            hold_d  = tbl_hold_q[next_step];
                            div_d   = '0;
                            state_d = S_RAMP;
                        end
                    end else if (period_tick) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            duty_q     <= '0;
            tgt_q      <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            div_q      <= '0;
            step_q     <= '0;
            upd_q      <= 1'b0;
            done_q     <= 1'b0;
            for (int unsigned i = 0; i < STEPS; i++) begin
                tbl_duty_q[i] <= '0;
                tbl_hold_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            tgt_q      <= tgt_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            div_q      <= div_d;
            step_q     <= step_d;
            upd_q      <= upd_d;
            done_q     <= done_d;
            tbl_duty_q <= tbl_duty_d;
            tbl_hold_q <= tbl_hold_d;
        end
    end

    assign duty_out    = duty_q;
    assign duty_update = upd_q;
    assign busy        = (state_q != S_IDLE);
    assign step_idx    = step_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pwm_pattern_sequencer.sv
// Bench for pwm_pattern_sequencer: countdown-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pwm_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_duty;
    logic [7:0] cfg_hold;
    logic [9:0] ramp_div;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic       period_tick;
    logic [5:0] duty_out;
    logic       duty_update;
    logic       busy;
    logic [1:0] step_idx;
    logic       done;

    pwm_pattern_sequencer #(
        .DUTY_W(6),
        .STEPS (4),
        .HOLD_W(8),
        .DIV_W (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_duty   (cfg_duty),
        .cfg_hold   (cfg_hold),
        .ramp_div   (ramp_div),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .period_tick(period_tick),
        .duty_out   (duty_out),
        .duty_update(duty_update),
        .busy       (busy),
        .step_idx   (step_idx),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int done_cnt = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: phases with countdowns of remaining ticks / hold periods.
    int m_tab_d [4];
    int m_tab_h [4];
    int m_phase;       // 0 idle, 1 moving toward target, 2 dwelling at target
    int m_duty, m_step, m_tgt, m_hold, m_hold_left, m_ticks_left;
    bit m_upd, m_done, m_cause, m_valid;

    function automatic void m_enter(int s);
        m_step       = s;
        m_tgt        = m_tab_d[s];
        m_hold       = m_tab_h[s];
        m_ticks_left = int'(ramp_div) + 1;
        m_phase      = 1;
    endfunction

    function automatic void m_abort();
        if (m_duty != 0) m_upd = 1;
        m_duty  = 0;
        m_step  = 0;
        m_phase = 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_phase = 0; m_duty = 0; m_step = 0; m_tgt = 0; m_hold = 0;
            m_hold_left = 0; m_ticks_left = 0; m_upd = 0; m_done = 0; m_cause = 0;
            for (int i = 0; i < 4; i++) begin
                m_tab_d[i] = 0;
                m_tab_h[i] = 0;
            end
        end else begin
            m_upd = 0;
            m_done = 0;
            m_cause = period_tick || stop;
            if (stop) begin
                m_abort();
            end else if (m_phase == 0) begin
                if (start) m_enter(0);
            end else if (m_phase == 1) begin
                if (m_duty == m_tgt) begin
                    m_phase = 2;
                    m_hold_left = m_hold;
                end else if (period_tick) begin
                    m_ticks_left--;
                    if (m_ticks_left == 0) begin
                        m_duty = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                        m_upd = 1;
                        m_ticks_left = int'(ramp_div) + 1;
                    end
                end
            end else begin
                if (m_hold_left == 0) begin
                    if (m_step == 3 && !loop_en) begin
                        m_phase = 0;
                        m_done = 1;
                    end else begin
                        m_enter((m_step + 1) % 4);
                    end
                end else if (period_tick) begin
                    m_hold_left--;
                end
            end
            if (cfg_we) begin
                m_tab_d[cfg_addr] = int'(cfg_duty);
                m_tab_h[cfg_addr] = int'(cfg_hold);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("duty_out", int'(duty_out), m_duty);
            chk("duty_update", int'(duty_update), int'(m_upd));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("step_idx", int'(step_idx), m_step);
            chk("done", int'(done), int'(m_done));
            if (duty_update) chk("update_without_tick_or_stop", int'(m_cause), 1);
        end
        if (duty_update) upd_cnt++;
        if (done) done_cnt++;
    end

    task automatic cyc();
        @(negedge clk);
        period_tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic ticks(int n, int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) cyc();
            cyc();
            period_tick = 1'b1;
        end
    endtask

    task automatic wr(int a, int d, int h);
        cyc();
        cfg_we = 1'b1;
        cfg_addr = 2'(a);
        cfg_duty = 6'(d);
        cfg_hold = 8'(h);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int seq [$];
        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_duty = 0; cfg_hold = 0;
        ramp_div = 0; start = 0; stop = 0; loop_en = 0; period_tick = 0;
        cyc(); cyc();
        chk("reset_duty", int'(duty_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_step", int'(step_idx), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;

        // One-shot walk through a mixed table with a tick every 64 clocks.
        wr(0, 40, 2); wr(1, 10, 0); wr(2, 10, 1); wr(3, 0, 0);
        ramp_div = 0; loop_en = 0;
        cyc(); upd_cnt = 0; done_cnt = 0; start = 1'b1;
        cyc(); cyc();
        chk("busy_after_start", int'(busy), 1);
        n = 0;
        while (busy && n < 200) begin ticks(1, 64); n++; end
        repeat (4) cyc();
        chk("t1_finished", int'(busy), 0);
        chk("t1_update_count", upd_cnt, 80);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_final_duty", int'(duty_out), 0);

        // Ramp divider 3: one LSB every 4th tick, done after 20 ticks.
        wr(0, 5, 0); wr(1, 5, 0); wr(2, 5, 0); wr(3, 5, 0);
        ramp_div = 3;
        cyc(); done_cnt = 0; start = 1'b1;
        cyc();
        for (int i = 1; i <= 20; i++) begin
            ticks(1, 16); cyc(); cyc();
            chk("t2_duty_vs_ticks", int'(duty_out), i / 4);
            chk("t2_no_early_done", done_cnt, 0);
        end
        repeat (16) cyc();
        chk("t2_done_count", done_cnt, 1);
        chk("t2_idle", int'(busy), 0);

        // Stop in IDLE clears a nonzero duty with one update pulse.
        ramp_div = 0;
        cyc(); upd_cnt = 0; stop = 1'b1;
        cyc(); cyc();
        chk("idle_stop_duty", int'(duty_out), 0);
        chk("idle_stop_pulse", upd_cnt, 1);

        // Looping table: step_idx runs 0,1,2,3,0 and done never fires.
        wr(0, 8, 1); wr(1, 0, 1); wr(2, 8, 1); wr(3, 0, 1);
        loop_en = 1;
        cyc(); done_cnt = 0; start = 1'b1;
        seq.delete();
        n = 0;
        while (n < 4000) begin
            cyc();
            if (seq.size() == 0 || seq[$] != int'(step_idx)) seq.push_back(int'(step_idx));
            if (seq.size() == 5) break;
            if (n % 8 == 7) period_tick = 1'b1;
            n++;
        end
        chk("t3_seq_len", seq.size(), 5);
        for (int k = 0; k < seq.size() && k < 5; k++) chk("t3_seq_entry", seq[k], k % 4);
        chk("t3_no_done", done_cnt, 0);
        ticks(3, 8); cyc();
        chk("t3_mid_ramp_duty", int'(duty_out), 3);
        stop = 1'b1;
        cyc();
        chk("t3_stop_duty", int'(duty_out), 0);
        chk("t3_stop_busy", int'(busy), 0);
        chk("t3_stop_step", int'(step_idx), 0);

        // start+stop together in IDLE: stop wins, nothing changes.
        cyc(); upd_cnt = 0; start = 1'b1; stop = 1'b1;
        cyc(); cyc(); cyc();
        chk("t4_startstop_busy", int'(busy), 0);
        chk("t4_startstop_no_update", upd_cnt, 0);

        // start while busy is ignored.
        start = 1'b1;
        n = 0;
        while (n < 4000) begin
            cyc();
            if (step_idx == 2'd1) break;
            if (n % 8 == 7) period_tick = 1'b1;
            n++;
        end
        chk("t4_reached_step1", int'(step_idx), 1);
        cyc(); start = 1'b1;
        cyc(); cyc();
        chk("t4_restart_ignored_step", int'(step_idx), 1);
        chk("t4_restart_ignored_busy", int'(busy), 1);

        // Rewriting the current entry during its hold does not affect this pass.
        n = 0;
        while (n < 4000) begin
            cyc();
            if (step_idx == 2'd2 && duty_out == 6'd8) break;
            if (n % 8 == 7) period_tick = 1'b1;
            n++;
        end
        chk("t5_in_step2_hold", int'(duty_out), 8);
        wr(2, 12, 1);
        ticks(1, 8); cyc(); cyc();
        chk("t5_advanced_step", int'(step_idx), 3);
        chk("t5_duty_unchanged", int'(duty_out), 8);
        n = 0;
        while (n < 4000) begin
            cyc();
            if (step_idx == 2'd2) break;
            if (n % 8 == 7) period_tick = 1'b1;
            n++;
        end
        ticks(12, 8); cyc();
        chk("t5_new_target_duty", int'(duty_out), 12);
        chk("t5_new_target_step", int'(step_idx), 2);
        ticks(1, 8);
        ticks(3, 8); cyc();
        chk("t5_step3_mid_ramp", int'(duty_out), 9);

        // Reset mid-ramp with a simultaneous write: write is discarded.
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 0; cfg_duty = 33; cfg_hold = 5;
        cyc(); rst = 1'b0;
        chk("t6_rst_duty", int'(duty_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_step", int'(step_idx), 0);
        chk("t6_rst_update", int'(duty_update), 0);
        loop_en = 0;
        cyc(); upd_cnt = 0; done_cnt = 0; start = 1'b1;
        repeat (20) cyc();
        chk("t6_cleared_done", done_cnt, 1);
        chk("t6_cleared_no_update", upd_cnt, 0);
        chk("t6_cleared_duty", int'(duty_out), 0);
        chk("t6_cleared_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_pattern_sequencer.md
Name: pwm_pattern_sequencer

Overview:
Sequences the PWM duty register through a small programmable table of (target duty, hold time) steps.
- Duty ramps toward each target by ±1 LSB, and holds there for a programmed number of PWM periods.
- Then advances to the next step, either one-shot or looping.
- Sits between the ui_in-driven configuration path and the PWM comparator. Replaces the fixed triangle generator with a programmable breathing/pattern engine.
- All duty changes are aligned to the PWM period wrap, so the comparator never sees a mid-period glitch.

Parameters:
DUTY_W, 6, width of duty value (matches 6-bit PWM counter)
STEPS, 4, number of pattern table entries (power of two)
HOLD_W, 8, width of per-step hold count, in PWM periods
DIV_W, 10, width of ramp divider, in PWM periods

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  log2(STEPS)  table entry to write
cfg_duty  in  DUTY_W  target duty for entry
cfg_hold  in  HOLD_W  hold periods for entry
ramp_div  in  DIV_W  ramp rate: one duty LSB per (ramp_div+1) period ticks
start  in  1  pulse; begin sequence at entry 0
stop  in  1  pulse; abort sequence
loop_en  in  1  1 = wrap from last entry to entry 0; 0 = finish
period_tick  in  1  1-cycle pulse at PWM counter wrap (counter 63->0)
duty_out  out  DUTY_W  duty presented to PWM comparator
duty_update  out  1  1-cycle pulse whenever duty_out changes
busy  out  1  high in RAMP/HOLD
step_idx  out  log2(STEPS)  current table entry
done  out  1  1-cycle pulse on one-shot completion

Behaviour:
Reset:
- rst synchronous; has priority over every other input.
- State IDLE, duty_out=0, step_idx=0, busy=0, done=0, duty_update=0, counters=0.
- Table cleared (all duty=0, hold=0).

Table writes:
- When cfg_we=1, the addressed entry is written on the clock edge, in any state.
- A write to the current step takes effect only at the next entry into that step, because the target and hold are latched on step entry.

IDLE:
- duty_out holds its value.
- start=1 -> latch entry 0 as target/hold, step_idx=0, div_cnt=0, go to RAMP. busy rises the cycle after start.

RAMP:
- Only period_tick cycles act.
- On a tick with div_cnt==ramp_div: div_cnt<=0. If duty_out<target, duty_out+1; if duty_out>target, duty_out-1. Pulse duty_update that cycle.
- On any other tick: div_cnt+1.
- When duty_out==target (checked every cycle, including on step entry): go to HOLD with hold_cnt=0. No duty_update pulse.

HOLD:
- On each period_tick: hold_cnt+1.
- When hold_cnt==latched hold (checked every cycle): advance. With hold=0, the step advances the cycle after reaching target.

Advance:
- step_idx<STEPS-1: step_idx+1, latch that entry, div_cnt=0, go to RAMP.
- step_idx==STEPS-1 and loop_en=1: step_idx=0, latch entry 0, go to RAMP.
- step_idx==STEPS-1 and loop_en=0: go to IDLE, pulse done. duty_out holds the last target.

Stop and start conflicts:
- stop=1 in RAMP/HOLD -> IDLE next cycle; duty_out<=0, with a duty_update pulse if it was nonzero; step_idx=0; no done pulse.
- stop in IDLE: duty_out<=0 (pulse if nonzero).
- start and stop in the same cycle: stop wins.
- start while busy: ignored.

Arithmetic and counters:
- Duty arithmetic is unsigned DUTY_W and never wraps, because the step direction always moves toward the target.
- div_cnt is DIV_W wide; hold_cnt is HOLD_W wide. Both compare for equality, so neither overflows.

Timing:
- All outputs are registered.
- Ramp latency: from entering RAMP to reaching target is |target-start| × (ramp_div+1) period ticks.

Test Plan:
- Reset, then table {0:(40,2),1:(10,0),2:(10,1),3:(0,0)}, ramp_div=0, loop_en=0, start. Drive period_tick every 64 clk -> duty_out steps 0→40 over 40 ticks, holds 2 ticks, falls to 10 over 30 ticks. Entry 2 needs no ramp and holds 1 tick; entry 3 ramps to 0. Then done pulses once, busy=0, duty_update count=80.
- ramp_div=3, entry0=(5,0), one-shot -> duty_out increments exactly every 4th period_tick; done after 20 ticks.
- loop_en=1, table {(8,1),(0,1),(8,1),(0,1)} -> step_idx cycles 0,1,2,3,0. done never asserts. Then stop mid-RAMP -> IDLE next cycle, duty_out=0, busy=0.
- start and stop asserted together in IDLE with duty_out=0 -> remains IDLE, no duty_update. start while busy -> step_idx unchanged.
- Rewrite the current entry's duty during HOLD -> current step unaffected; new value used on the next loop. Assert rst mid-RAMP with cfg_we=1 -> all outputs 0 and the table cleared (write discarded).
- Check no duty_update ever occurs on a cycle without period_tick, except the stop/IDLE clear.
